// File: rtl/keypad_scanner_if.sv
// Keypad scanner bundle: matrix lines plus the confirmed-key handshake.
// Latency: none, wires only.
// Backpressure: key_valid is held by the scanner until key_ack; later presses overwrite the code and raise overrun.
interface keypad_scanner_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    localparam int CODE_W = $clog2(ROWS * COLS + 1);

    logic [ROWS-1:0]   row_in;
    logic [COLS-1:0]   col_out;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_ack;
    logic              key_held;
    logic              overrun;

    // Scanner side: senses rows, drives strobes and the key report.
    modport master (
        input  row_in,
        input  key_ack,
        output col_out,
        output key_code,
        output key_valid,
        output key_held,
        output overrun
    );

    // Keypad and consumer side.
    modport slave (
        output row_in,
        output key_ack,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  overrun
    );
endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column strobe, ghost rejection, press/release debounce, one report per press.
// Latency: press confirmed DEBOUNCE+1 cycles after the last-dwell sample; release after DEBOUNCE+1 quiet cycles.
// Backpressure: key_valid holds until key_ack; a new confirm while pending overwrites key_code and sets overrun.
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 16
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master kp
);
    localparam int NO_KEY = ROWS * COLS;
    localparam int CODE_W = $clog2(ROWS * COLS + 1);
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW     = $clog2(SCAN_DIV);
    localparam int BW     = $clog2(DEBOUNCE + 1);

    localparam logic [1:0] S_SCAN     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_PRESSED  = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    localparam logic [DW-1:0]     DWELL_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0]     DEB_LAST    = BW'(DEBOUNCE - 1);
    localparam logic [CW-1:0]     COL_LAST    = CW'(COLS - 1);
    localparam logic [CODE_W-1:0] NO_KEY_CODE = CODE_W'(NO_KEY);
    localparam logic [ROWS-1:0]   ROW_ONE     = ROWS'(1);
    localparam logic [COLS-1:0]   COL_ONE     = COLS'(1);

    logic [1:0]        r_state;
    logic [CW-1:0]     r_col_idx;
    logic [COLS-1:0]   r_col;
    logic [DW-1:0]     r_dwell;
    logic [BW-1:0]     r_deb_cnt;
    logic [ROWS-1:0]   r_cand_row;
    logic [CODE_W-1:0] r_cand_code;
    logic [CODE_W-1:0] r_key_code;
    logic              r_key_valid;
    logic              r_overrun;

    logic [RW-1:0]     w_row_idx;
    logic              w_one_hot;
    logic              w_row_match;
    logic              w_row_zero;
    logic              w_confirm;
    logic              w_handshake;
    logic [CW-1:0]     w_col_next_idx;
    logic [COLS-1:0]   w_col_next_oh;
    logic [CODE_W-1:0] w_cand_code;

    // Index of the active row; only meaningful when exactly one row is high.
    always_comb begin
        w_row_idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (kp.row_in[i]) begin
                w_row_idx = RW'(i);
            end
        end
    end

    // Two or more rows in the same column cannot be resolved, so only a single row counts as a key.
    assign w_one_hot      = (kp.row_in != '0) && ((kp.row_in & (kp.row_in - ROW_ONE)) == '0);
    assign w_row_match    = (kp.row_in == r_cand_row);
    assign w_row_zero     = (kp.row_in == '0);
    assign w_cand_code    = CODE_W'(r_col_idx) * CODE_W'(ROWS) + CODE_W'(w_row_idx);
    assign w_col_next_idx = (r_col_idx == COL_LAST) ? '0 : r_col_idx + CW'(1);
    assign w_col_next_oh  = COL_ONE << w_col_next_idx;
    assign w_confirm      = (r_state == S_DEBOUNCE) && w_row_match && (r_deb_cnt == DEB_LAST);
    assign w_handshake    = r_key_valid && kp.key_ack;

    // Scan / debounce state machine with column strobe, dwell and stability counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_SCAN;
            r_col_idx   <= '0;
            r_col       <= COL_ONE;
            r_dwell     <= '0;
            r_deb_cnt   <= '0;
            r_cand_row  <= '0;
            r_cand_code <= NO_KEY_CODE;
        end else begin
            case (r_state)
                S_SCAN: begin
                    if (r_dwell == DWELL_LAST) begin
                        r_dwell <= '0;
                        if (w_one_hot) begin
                            // Column stays frozen while the candidate is debounced.
                            r_cand_row  <= kp.row_in;
                            r_cand_code <= w_cand_code;
                            r_deb_cnt   <= '0;
                            r_state     <= S_DEBOUNCE;
                        end else begin
                            r_col_idx <= w_col_next_idx;
                            r_col     <= w_col_next_oh;
                        end
                    end else begin
                        r_dwell <= r_dwell + DW'(1);
                    end
                end
                S_DEBOUNCE: begin
                    if (w_row_match) begin
                        if (r_deb_cnt == DEB_LAST) begin
                            r_deb_cnt <= '0;
                            r_state   <= S_PRESSED;
                        end else begin
                            r_deb_cnt <= r_deb_cnt + BW'(1);
                        end
                    end else begin
                        r_deb_cnt <= '0;
                        r_dwell   <= '0;
                        r_col_idx <= w_col_next_idx;
                        r_col     <= w_col_next_oh;
                        r_state   <= S_SCAN;
                    end
                end
                S_PRESSED: begin
                    if (!w_row_match) begin
                        r_deb_cnt <= '0;
                        r_state   <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (w_row_zero) begin
                        if (r_deb_cnt == DEB_LAST) begin
                            r_deb_cnt <= '0;
                            r_dwell   <= '0;
                            r_col_idx <= w_col_next_idx;
                            r_col     <= w_col_next_oh;
                            r_state   <= S_SCAN;
                        end else begin
                            r_deb_cnt <= r_deb_cnt + BW'(1);
                        end
                    end else if (w_row_match) begin
                        // Key bounced back: resume the hold without a new report.
                        r_deb_cnt <= '0;
                        r_state   <= S_PRESSED;
                    end else begin
                        r_deb_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= S_SCAN;
                end
            endcase
        end
    end

    // Key report register: confirm beats ack; overrun is sticky until a handshake without a new overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_code  <= NO_KEY_CODE;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_confirm) begin
                r_key_code  <= r_cand_code;
                r_key_valid <= 1'b1;
            end else if (kp.key_ack) begin
                r_key_valid <= 1'b0;
            end

            if (w_confirm && r_key_valid && !kp.key_ack) begin
                r_overrun <= 1'b1;
            end else if (w_handshake) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign kp.col_out   = r_col;
    assign kp.key_code  = r_key_code;
    assign kp.key_valid = r_key_valid;
    assign kp.key_held  = (r_state == S_PRESSED) || (r_state == S_RELEASE);
    assign kp.overrun   = r_overrun;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a key-report scoreboard.
// Latency: presses placed at the last dwell cycle of their column; confirms expected DEBOUNCE+1 edges later.
// Backpressure: acks driven explicitly to exercise pending, overrun and immediate-ack paths.
module tb_keypad_scanner;
    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int NO_KEY   = ROWS * COLS;

    logic clk = 1'b0;
    logic rst;

    keypad_scanner_if #(.ROWS(ROWS), .COLS(COLS)) kp ();

    keypad_scanner #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp (kp)
    );

    always #5 clk = ~clk;

    int n_cmp    = 0;
    int n_err    = 0;
    int n_events = 0;
    int exp_q[$];
    int obs_q[$];

    logic       prev_valid = 1'b0;
    logic [4:0] prev_code  = 5'd0;

    // Key-report monitor: a new report is key_valid rising or the code changing while valid.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (kp.key_valid && (!prev_valid || kp.key_code != prev_code)) begin
                obs_q.push_back(int'(kp.key_code));
                n_events++;
            end
            prev_valid = kp.key_valid;
            prev_code  = kp.key_code;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait for the strobe to move onto column idx; returns at dwell 0 of that column.
    task automatic wait_col(input int idx);
        logic [COLS-1:0] target;
        logic [COLS-1:0] prev;
        bit              seen;
        seen   = 1'b0;
        target = COLS'(1) << idx;
        prev   = kp.col_out;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (kp.col_out == target && prev != target) seen = 1'b1;
            prev = kp.col_out;
        end
        chk("wait_col", 32'(seen), 1);
    endtask

    // Present the key on its column's last dwell cycle and hold it through the debounce window.
    task automatic press_at(input int code);
        wait_col(code / ROWS);
        repeat (SCAN_DIV - 1) tick();
        kp.row_in = ROWS'(1) << (code % ROWS);
        exp_q.push_back(code);
        repeat (DEBOUNCE + 1) tick();
    endtask

    task automatic release_key();
        kp.row_in = '0;
        repeat (DEBOUNCE + 1) tick();
    endtask

    task automatic ack();
        kp.key_ack = 1'b1;
        tick();
        kp.key_ack = 1'b0;
    endtask

    task automatic sb_check(input string tag);
        bit got;
        int e;
        int o;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (obs_q.size() > 0) got = 1'b1;
            else tick();
        end
        chk({tag, "_seen"}, 32'(got), 1);
        if (got && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_code"}, o, e);
        end
    endtask

    int ev0;

    initial begin
        rst        = 1'b1;
        kp.row_in  = '0;
        kp.key_ack = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_col",   kp.col_out, 4'b0001);
        chk("rst_code",  kp.key_code, NO_KEY);
        chk("rst_valid", kp.key_valid, 0);
        chk("rst_held",  kp.key_held, 0);
        chk("rst_ovr",   kp.overrun, 0);
        rst = 1'b0;

        // Ghost: two rows on column 0 are ignored and the scan moves on
        wait_col(0);
        repeat (SCAN_DIV - 1) tick();
        kp.row_in = 4'b0011;
        tick();
        chk("ghost_col", kp.col_out, 4'b0010);
        kp.row_in = '0;
        tick();
        chk("ghost_code",  kp.key_code, NO_KEY);
        chk("ghost_valid", kp.key_valid, 0);
        chk("ghost_held",  kp.key_held, 0);

        // Bounce: one debounce match then gone
        wait_col(1);
        repeat (SCAN_DIV - 1) tick();
        kp.row_in = 4'b0001;
        tick();
        chk("bounce_frozen", kp.col_out, 4'b0010);
        tick();
        kp.row_in = '0;
        tick();
        chk("bounce_col",   kp.col_out, 4'b0100);
        chk("bounce_valid", kp.key_valid, 0);
        chk("bounce_noev",  obs_q.size(), 0);

        // Clean press of key 10 (column 2, row 2)
        press_at(10);
        chk("clean_valid", kp.key_valid, 1);
        chk("clean_code",  kp.key_code, 10);
        chk("clean_held",  kp.key_held, 1);
        sb_check("clean");
        ack();
        chk("clean_ack_valid", kp.key_valid, 0);
        chk("clean_ack_code",  kp.key_code, 10);
        release_key();
        chk("clean_rel_held", kp.key_held, 0);
        chk("clean_rel_col",  kp.col_out, 4'b1000);

        // Overrun: code 5 left pending, then code 15 confirmed
        chk("ovr_pre", kp.overrun, 0);
        press_at(5);
        sb_check("ovr_first");
        chk("ovr_first_valid", kp.key_valid, 1);
        chk("ovr_first_flag",  kp.overrun, 0);
        release_key();
        press_at(15);
        chk("ovr_code",  kp.key_code, 15);
        chk("ovr_valid", kp.key_valid, 1);
        chk("ovr_flag",  kp.overrun, 1);
        sb_check("ovr_second");
        ack();
        chk("ovr_ack_valid", kp.key_valid, 0);
        chk("ovr_ack_flag",  kp.overrun, 0);
        release_key();

        // Long hold of key 0 with immediate ack: a single report
        ev0 = n_events;
        press_at(0);
        ack();
        sb_check("hold");
        repeat (50) tick();
        chk("hold_held",  kp.key_held, 1);
        chk("hold_valid", kp.key_valid, 0);
        release_key();
        chk("hold_events",   n_events - ev0, 1);
        chk("hold_rel_held", kp.key_held, 0);

        // Reset while PRESSED aborts asynchronously
        press_at(9);
        sb_check("rstp");
        chk("rstp_held", kp.key_held, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstp_code",  kp.key_code, NO_KEY);
        chk("rstp_col",   kp.col_out, 4'b0001);
        chk("rstp_valid", kp.key_valid, 0);
        chk("rstp_held",  kp.key_held, 0);
        kp.row_in = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rstp_resume_col", kp.col_out, 4'b0001);
        repeat (SCAN_DIV) tick();
        chk("rstp_next_col", kp.col_out, 4'b0010);
        chk("rstp_noev",     obs_q.size(), 0);

        chk("end_obs_empty", obs_q.size(), 0);
        chk("end_exp_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
